spi_log_framer: RTL
===================

Name: spi_log_framer

Overview:
Parametrised successor to the top-level SPI bus logger. It captures decoded SPI bytes (cmd/mosi/miso strobes from spi_device), formats them into fixed-layout records according to a selectable mode, and buffers them in a byte FIFO. It drains the FIFO to the serial transmit interface (USB serial or FTDI uart) under a ready handshake. Records are all-or-nothing: a record that does not fit is dropped and counted.

Parameters:
DEPTH, 512, FIFO depth in bytes (power of two, >= 8)
ADDR_BYTES, 3, address bytes following a command (1..4)
MAX_BYTES, 16, per-transaction byte limit logged in PAIR mode (1..65535)

Ports:
clk  in  1  system clock (132 MHz domain)
reset  in  1  asynchronous, active-high
enable  in  1  capture enable; 0 = no new records, drain continues
mode  in  2  0 RAW, 1 PAIR, 2 TXN, 3 reserved (no capture)
spi_cs  in  1  active-low chip select, already synchronised to clk
spi_rx_strobe  in  1  one-cycle pulse per completed SPI byte
spi_rx_cmd  in  1  qualifies strobe: first byte after CS fall
spi_rx_data  in  8  mosi byte
spi_rx_miso  in  8  miso byte
uart_txd_ready  in  1  sink can accept a byte this cycle
uart_txd  out  8  byte to serial port
uart_txd_strobe  out  1  one-cycle write pulse
overflow_count  out  16  dropped records, saturating
fifo_level  out  log2(DEPTH)+1  bytes currently buffered
busy  out  1  staging non-empty or FIFO non-empty

Behaviour:
- Reset: uart_txd=0, uart_txd_strobe=0, overflow_count=0, fifo_level=0, busy=0, staging empty, idx=0, cmd_seen=0.
- Mode is latched on each cmd strobe (txn_mode); mode changes mid-transaction have no effect until the next cmd.
- idx counter: cleared to 0 on cmd; increments on each non-cmd strobe; saturates at 16'hFFFF.
- RAW (0): cmd strobe produces a 1-byte record {data}. A non-cmd strobe with idx < ADDR_BYTES (before increment) produces {data}. Later bytes produce nothing.
- PAIR (1): each strobe with idx < MAX_BYTES produces a 4-byte record {idx_hi, idx_lo, mosi, miso}. For a cmd, idx=0; the first following byte is 1.
- TXN (2): address bytes are accumulated MSB first. On CS rising edge (spi_cs 0->1, detected with a registered prev) with cmd_seen=1, a (3+ADDR_BYTES)-byte record is produced: {cmd, addr[ADDR_BYTES], len_hi, len_lo}.
  - len = max(idx - ADDR_BYTES, 0), saturating 16 bits.
  - If CS rises before all address bytes arrive, missing address bytes are 0.
  - cmd_seen is cleared on CS rise.
  - If a strobe and the CS rise occur in the same cycle, the byte is counted first.
- enable=0 or mode 3: no records; counters still track.
- Admission: a record is accepted only if the staging buffer is empty and FIFO free space >= record length, evaluated in the generating cycle. Otherwise the whole record is dropped and overflow_count increments, saturating at 16'hFFFF.
- Staging: an 8-byte shift register plus count. One byte is pushed into the FIFO per clk, so a record occupies staging for 1-7 cycles. SPI byte spacing is >= 16 clk, so there is no conflict in normal use.
- Drain: when FIFO is non-empty and uart_txd_ready=1, the block pops and registers uart_txd with uart_txd_strobe=1 in the next cycle. Back-to-back strobes are allowed while ready stays high. A strobe is never issued when ready was low in the sampling cycle.
- FIFO:
  - Simultaneous push and pop is allowed; level remains unchanged.
  - Pointers wrap modulo DEPTH.
  - A push never occurs when full; this is guaranteed by admission.
- Reset mid-record: staging and FIFO are discarded and no partial output occurs. uart_txd_strobe is forced low immediately (async).

Decomposition:
- Package spi_log_pkg: mode constants MODE_RAW/PAIR/TXN/RSVD, record-length function rec_len(mode, ADDR_BYTES), STAGE_BYTES=8.
- Sub-module: fifo_sync (parametrised width 8, DEPTH; push/pop/level/full/empty, async active-high reset), reusable by the uart.

Test Plan:
- RAW, ADDR_BYTES=3: cmd 03, then 12 34 56 78 9A -> uart emits 03 12 34 56 only; overflow_count=0.
- PAIR, MAX_BYTES=2: cmd 0B/miso FF, bytes AA/01, BB/02, CC/03 -> emits 00 00 0B FF 00 01 AA 01; CC not logged.
- TXN, ADDR_BYTES=3: cmd 03, addr 00 10 00, 300 data bytes, CS rise -> emits 03 00 10 00 01 2C. CS rise after only cmd 05 -> 05 00 00 00 00 00.
- Backpressure: DEPTH=8, ready=0, PAIR records x3 -> first two accepted (fifo_level=8), third dropped (overflow_count=1). Raise ready -> 8 strobes with exact bytes, then busy=0.
- Mode change mid-transaction: cmd in RAW, switch mode to PAIR before address bytes -> RAW formatting persists until the next cmd.
- Reset asserted while staging holds 4 bytes with ready=1 -> strobe low immediately; after release fifo_level=0, no stale bytes emitted.

Source files
------------

// File: rtl/spi_log_pkg.sv
// Shared constants and helpers for the SPI bus log framer.
package spi_log_pkg;

  localparam logic [1:0] MODE_RAW  = 2'd0;
  localparam logic [1:0] MODE_PAIR = 2'd1;
  localparam logic [1:0] MODE_TXN  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Staging buffer holds the longest record (TXN with 4 address bytes = 7).
  localparam int STAGE_BYTES = 8;

  // Number of bytes a record occupies for a given mode; 0 means "no record".
  function automatic logic [3:0] rec_len(input logic [1:0] m, input int addr_bytes);
    case (m)
      MODE_RAW:  rec_len = 4'd1;
      MODE_PAIR: rec_len = 4'd4;
      MODE_TXN:  rec_len = 4'(3 + addr_bytes);
      default:   rec_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock byte FIFO with occupancy count; pointers wrap modulo DEPTH.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Guard against writes when full and reads when empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr];
  assign level = count;
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == LW'(0));

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves level unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_log_framer.sv
// Formats decoded SPI bytes into fixed-layout records, buffers them in a
// byte FIFO and drains them to the serial transmit port under ready.
module spi_log_framer
  import spi_log_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_BYTES = 3,
  parameter int MAX_BYTES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     spi_cs,
  input  logic                     spi_rx_strobe,
  input  logic                     spi_rx_cmd,
  input  logic [7:0]               spi_rx_data,
  input  logic [7:0]               spi_rx_miso,
  input  logic                     uart_txd_ready,
  output logic [7:0]               uart_txd,
  output logic                     uart_txd_strobe,
  output logic [15:0]              overflow_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int SW = STAGE_BYTES * 8;

  // Transaction tracking state
  logic        cs_prev;
  logic        cs_rise;
  logic [1:0]  txn_mode;
  logic [1:0]  mode_eff;
  logic [15:0] idx;
  logic [15:0] idx_nx;
  logic        cmd_seen;
  logic        cmd_seen_nx;
  logic [7:0]  cmd_byte;
  logic [7:0]  cmd_nx;
  logic [7:0]  addr    [ADDR_BYTES];
  logic [7:0]  addr_nx [ADDR_BYTES];
  logic [15:0] len;

  // Record generation and staging
  logic          gen;
  logic [3:0]    gen_len;
  logic [SW-1:0] gen_rec;
  logic          accept;
  logic [SW-1:0] stage;
  logic [3:0]    stage_cnt;
  logic          push;

  // FIFO side
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [LW-1:0] free_space;

  assign cs_rise = spi_cs && !cs_prev;

  // Next-state of the transaction tracker: the current strobe is folded in
  // first so a byte arriving in the same cycle as CS rise is counted.
  always_comb begin
    idx_nx      = idx;
    cmd_seen_nx = cmd_seen;
    cmd_nx      = cmd_byte;
    mode_eff    = txn_mode;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      addr_nx[i] = addr[i];
    end
    if (spi_rx_strobe) begin
      if (spi_rx_cmd) begin
        idx_nx      = 16'd0;
        cmd_seen_nx = 1'b1;
        cmd_nx      = spi_rx_data;
        mode_eff    = mode;
        for (int i = 0; i < ADDR_BYTES; i++) begin
          addr_nx[i] = 8'd0;
        end
      end else begin
        if (idx != 16'hFFFF) begin
          idx_nx = idx + 16'd1;
        end else begin
          idx_nx = idx;
        end
        // Address bytes land by position, so missing trailing bytes stay 0.
        for (int i = 0; i < ADDR_BYTES; i++) begin
          if (idx == 16'(i)) begin
            addr_nx[i] = spi_rx_data;
          end else begin
            addr_nx[i] = addr[i];
          end
        end
      end
    end else begin
      idx_nx = idx;
    end
  end

  // Data length of a TXN record: bytes beyond the address phase.
  always_comb begin
    if (idx_nx > 16'(ADDR_BYTES)) begin
      len = idx_nx - 16'(ADDR_BYTES);
    end else begin
      len = 16'd0;
    end
  end

  // Build the candidate record for this cycle, first byte in the top lane.
  always_comb begin
    gen     = 1'b0;
    gen_rec = '0;
    gen_len = rec_len(mode_eff, ADDR_BYTES);
    if (enable) begin
      case (mode_eff)
        MODE_RAW: begin
          if (spi_rx_strobe && (spi_rx_cmd || (idx < 16'(ADDR_BYTES)))) begin
            gen               = 1'b1;
            gen_rec[SW-1 -: 8] = spi_rx_data;
          end else begin
            gen = 1'b0;
          end
        end
        MODE_PAIR: begin
          if (spi_rx_strobe && (idx_nx < 16'(MAX_BYTES))) begin
            gen                 = 1'b1;
            gen_rec[SW-1 -: 32] = {idx_nx, spi_rx_data, spi_rx_miso};
          end else begin
            gen = 1'b0;
          end
        end
        MODE_TXN: begin
          if (cs_rise && cmd_seen_nx) begin
            gen                = 1'b1;
            gen_rec[SW-1 -: 8] = cmd_nx;
            for (int i = 0; i < ADDR_BYTES; i++) begin
              gen_rec[SW-9-8*i -: 8] = addr_nx[i];
            end
            gen_rec[SW-9-8*ADDR_BYTES -: 16] = len;
          end else begin
            gen = 1'b0;
          end
        end
        default: gen = 1'b0;
      endcase
    end else begin
      gen = 1'b0;
    end
  end

  // All-or-nothing admission against staging occupancy and FIFO room.
  assign free_space = LW'(DEPTH) - fifo_level;
  assign accept     = gen && (stage_cnt == 4'd0) && !fifo_full &&
                      (free_space >= LW'(gen_len));
  assign push       = (stage_cnt != 4'd0);
  assign pop        = !fifo_empty && uart_txd_ready;
  assign busy       = push || !fifo_empty;

  // Transaction tracker registers; CS rise closes the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_prev  <= 1'b1;
      txn_mode <= MODE_RAW;
      idx      <= 16'd0;
      cmd_seen <= 1'b0;
      cmd_byte <= 8'd0;
      for (int i = 0; i < ADDR_BYTES; i++) begin
        addr[i] <= 8'd0;
      end
    end else begin
      cs_prev  <= spi_cs;
      txn_mode <= mode_eff;
      idx      <= idx_nx;
      cmd_seen <= cs_rise ? 1'b0 : cmd_seen_nx;
      cmd_byte <= cmd_nx;
      for (int i = 0; i < ADDR_BYTES; i++) begin
        addr[i] <= addr_nx[i];
      end
    end
  end

  // Staging shift register: load an accepted record, then feed one byte per clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage     <= '0;
      stage_cnt <= 4'd0;
    end else if (accept) begin
      stage     <= gen_rec;
      stage_cnt <= gen_len;
    end else if (push) begin
      stage     <= {stage[SW-9:0], 8'd0};
      stage_cnt <= stage_cnt - 4'd1;
    end
  end

  // Dropped-record counter, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_count <= 16'd0;
    end else if (gen && !accept && (overflow_count != 16'hFFFF)) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end

  // Registered transmit port: one strobe per popped byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_txd        <= 8'd0;
      uart_txd_strobe <= 1'b0;
    end else if (pop) begin
      uart_txd        <= fifo_rdata;
      uart_txd_strobe <= 1'b1;
    end else begin
      uart_txd_strobe <= 1'b0;
    end
  end

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (stage[SW-1 -: 8]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
